fetch_decode_stage1: RTL and testbench

Stage-1 controller of the pipelined BPF CPU: owns the program counter, fetches 64-bit BPF instructions from instruction memory, decodes which of A/X each instruction reads, and issues it to stage 2 under a valid/ready handshake. It is the consumer of the stage-2 and stage-3 register-write enables (A_en, X_en). It stalls issue while any in-flight write targets a register the held instruction reads. It also applies branch redirects returned from stage 2.

---
 rtl/bpf_stage_pkg.sv | 71 +++++++
 rtl/bpf_read_set_decode.sv | 38 +++
 rtl/fetch_decode_stage1.sv | 155 +++++++++++++++
 tb/tb_fetch_decode_stage1.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_stage_pkg.sv
// Shared definitions for the BPF pipeline stage-1 controller: instruction
// layout, class codes, addressing/source masks, special opcodes and the
// stage-1 state enum.
package bpf_stage_pkg;

  // Instruction word layout: {opcode[63:48], jt[47:40], jf[39:32], k[31:0]}
  localparam int INST_W     = 64;
  localparam int OPCODE_W   = 16;
  localparam int JT_W       = 8;
  localparam int JF_W       = 8;
  localparam int K_W        = 32;
  localparam int OPCODE_LSB = 48;
  localparam int JT_LSB     = 40;
  localparam int JF_LSB     = 32;
  localparam int K_LSB      = 0;

  // Instruction class lives in opcode[2:0]
  typedef enum logic [2:0] {
    CLS_LD   = 3'd0,
    CLS_LDX  = 3'd1,
    CLS_ST   = 3'd2,
    CLS_STX  = 3'd3,
    CLS_ALU  = 3'd4,
    CLS_JMP  = 3'd5,
    CLS_RET  = 3'd6,
    CLS_MISC = 3'd7
  } bpf_class_e;

  // Addressing mode field of LD and its indirect encoding
  localparam logic [7:0] MODE_MASK = 8'hE0;
  localparam logic [7:0] MODE_IND  = 8'h40;
  // Source-operand bit of ALU/JMP: set means the operand is X
  localparam logic [7:0] SRC_X     = 8'h08;
  // Return-value field of RET and its "return A" encoding
  localparam logic [7:0] RVAL_MASK = 8'h18;
  localparam logic [7:0] RVAL_A    = 8'h10;

  // Opcodes that need exact matching
  localparam logic [7:0] OP_TAX = 8'h07;
  localparam logic [7:0] OP_TXA = 8'h87;
  localparam logic [7:0] OP_JA  = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } stage1_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [JT_W-1:0]     jt;
    logic [JF_W-1:0]     jf;
    logic [K_W-1:0]      k;
  } bpf_inst_t;

  // Split a raw memory word into its named fields
  function automatic bpf_inst_t unpack_inst(input logic [INST_W-1:0] raw);
    bpf_inst_t f;
    f.opcode = raw[OPCODE_LSB +: OPCODE_W];
    f.jt     = raw[JT_LSB +: JT_W];
    f.jf     = raw[JF_LSB +: JF_W];
    f.k      = raw[K_LSB +: K_W];
    return f;
  endfunction

  // Class of an instruction from the low opcode byte
  function automatic bpf_class_e inst_class(input logic [7:0] op_lo);
    return bpf_class_e'(op_lo[2:0]);
  endfunction

endpackage

// File: rtl/bpf_read_set_decode.sv
// Combinational decode of which accumulator registers (A, X) an instruction
// reads, from the low byte of its opcode.
module bpf_read_set_decode
  import bpf_stage_pkg::*;
(
  input  logic [7:0] op_lo,
  output logic       reads_A,
  output logic       reads_X
);

  // Read-set table indexed by instruction class
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    reads_A = 1'b0;
    reads_X = 1'b0;
    case (inst_class(op_lo))
      CLS_LD:   reads_X = ((op_lo & MODE_MASK) == MODE_IND);
      CLS_LDX:  ;
      CLS_ST:   reads_A = 1'b1;
      CLS_STX:  reads_X = 1'b1;
      CLS_ALU: begin
        reads_A = 1'b1;
        reads_X = ((op_lo & SRC_X) != 8'h00);
      end
      CLS_JMP: begin
        // Unconditional JA compares nothing; conditional jumps compare A
        reads_A = (op_lo != OP_JA);
        reads_X = ((op_lo & SRC_X) != 8'h00);
      end
      CLS_RET:  reads_A = ((op_lo & RVAL_MASK) == RVAL_A);
      CLS_MISC: begin
        reads_A = (op_lo == OP_TAX);
        reads_X = (op_lo == OP_TXA);
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage1.sv
// Stage-1 of the pipelined BPF CPU: program counter, instruction fetch,
// read-set decode, A/X write hazard stall, branch redirect and valid/ready
// issue to stage 2.
// Optional feature macro: STALL_COUNTER_EN adds a saturating stall_cycles
// counter output counting hazard-blocked issue cycles.
module fetch_decode_stage1
  import bpf_stage_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                inst_rd_en,
  output logic [PC_WIDTH-1:0] inst_rd_addr,
  input  logic [63:0]         inst_rd_data,
  input  logic                s2_A_en,
  input  logic                s2_X_en,
  input  logic                s3_A_en,
  input  logic                s3_X_en,
  input  logic                branch_valid,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                s2_ready,
  output logic                valid_out,
  output logic [15:0]         opcode_out,
  output logic [7:0]          jt_out,
  output logic [7:0]          jf_out,
  output logic [31:0]         k_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                reads_A,
  output logic                reads_X,
  output logic                hazard_stall,
  output logic                busy
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  stage1_state_e       state, state_d;
  logic [PC_WIDTH-1:0] pc, pc_d;
  bpf_inst_t           ir, ir_d;
  logic                rd_en_q, rd_en_d;
  // Read data is due this cycle (a read was strobed last cycle and not cancelled)
  logic                data_due_q, data_due_d;

  logic hazard;
  logic in_issue;
  logic transfer;
  logic is_ret;

  bpf_read_set_decode u_read_set (
    .op_lo   (ir.opcode[7:0]),
    .reads_A (reads_A),
    .reads_X (reads_X)
  );

  // Hazard and issue qualification for the held instruction
  always_comb begin
    in_issue     = (state == ST_ISSUE);
    hazard       = (reads_A & (s2_A_en | s3_A_en)) | (reads_X & (s2_X_en | s3_X_en));
    hazard_stall = in_issue & hazard;
    // A redirect drops the held instruction, so it is never offered that cycle
    valid_out    = in_issue & ~hazard & ~branch_valid;
    transfer     = valid_out & s2_ready;
    is_ret       = (inst_class(ir.opcode[7:0]) == CLS_RET);
  end

  // Next-state, next-PC and fetch strobe
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_d       = ir;
    rd_en_d    = 1'b0;
    data_due_d = rd_en_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pc_d    = '0;
          rd_en_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (branch_valid) begin
          // Any read in flight belongs to the old path and must not be captured
          pc_d       = branch_target;
          rd_en_d    = 1'b1;
          data_due_d = 1'b0;
        end else if (data_due_q) begin
          ir_d    = unpack_inst(inst_rd_data);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (branch_valid) begin
          pc_d    = branch_target;
          rd_en_d = 1'b1;
          state_d = ST_FETCH;
        end else if (transfer) begin
          if (is_ret) begin
            state_d = ST_IDLE;
          end else begin
            pc_d    = pc + PC_WIDTH'(1);
            rd_en_d = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC, instruction register and read pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      // NOTE: the instruction register is reset so decoded outputs are defined out of reset.
      ir         <= '0;
      rd_en_q    <= 1'b0;
      data_due_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state      <= state_d;
      pc         <= pc_d;
      ir         <= ir_d;
      rd_en_q    <= rd_en_d;
      data_due_q <= data_due_d;
    end
  end

  assign inst_rd_en   = rd_en_q;
  assign inst_rd_addr = pc;
  assign pc_out       = pc;
  assign opcode_out   = ir.opcode;
  assign jt_out       = ir.jt;
  assign jf_out       = ir.jf;
  assign k_out        = ir.k;
  assign busy         = (state != ST_IDLE);

`ifdef STALL_COUNTER_EN
  // Saturating count of issue cycles lost to hazards; cleared by an accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cycles <= '0;
    end else if (hazard_stall && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_stage1.sv
// Self-checking bench for fetch_decode_stage1: directed scenarios followed by
// randomized traffic, all compared against a transaction-level latency model.
module tb_fetch_decode_stage1;

  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          inst_rd_en;
  logic [PW-1:0] inst_rd_addr;
  logic [63:0]   inst_rd_data = '0;
  logic          s2_A_en = 1'b0, s2_X_en = 1'b0, s3_A_en = 1'b0, s3_X_en = 1'b0;
  logic          branch_valid = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          s2_ready = 1'b0;
  logic          valid_out;
  logic [15:0]   opcode_out;
  logic [7:0]    jt_out, jf_out;
  logic [31:0]   k_out;
  logic [PW-1:0] pc_out;
  logic          reads_A, reads_X, hazard_stall, busy;
`ifdef STALL_COUNTER_EN
  logic [31:0]   stall_cycles;
`endif

  fetch_decode_stage1 #(.PC_WIDTH(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .inst_rd_en    (inst_rd_en),
    .inst_rd_addr  (inst_rd_addr),
    .inst_rd_data  (inst_rd_data),
    .s2_A_en       (s2_A_en),
    .s2_X_en       (s2_X_en),
    .s3_A_en       (s3_A_en),
    .s3_X_en       (s3_X_en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .s2_ready      (s2_ready),
    .valid_out     (valid_out),
    .opcode_out    (opcode_out),
    .jt_out        (jt_out),
    .jf_out        (jf_out),
    .k_out         (k_out),
    .pc_out        (pc_out),
    .reads_A       (reads_A),
    .reads_X       (reads_X),
    .hazard_stall  (hazard_stall),
    .busy          (busy)
`ifdef STALL_COUNTER_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: data valid exactly one cycle after the strobe, junk otherwise
  logic [63:0] mem [0:(1<<PW)-1];
  always @(posedge clk)
    inst_rd_data <= inst_rd_en ? mem[inst_rd_addr] : {$urandom(), $urandom()};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: busy flag, cycles until the instruction at m_pc is
  // offered (2 = strobe cycle, 1 = data cycle, 0 = offered), stall count.
  bit          m_busy  = 1'b0;
  int          m_wait  = 0;
  logic [PW-1:0] m_pc  = '0;
  int unsigned m_stall = 0;

  // Registers read by an instruction, {A, X}, straight from the read-set rules
  function automatic logic [1:0] exp_reads(input logic [7:0] op);
    logic a, x;
    a = 1'b0;
    x = 1'b0;
    case (op[2:0])
      3'd0: x = (op[7:5] == 3'b010);
      3'd2: a = 1'b1;
      3'd3: x = 1'b1;
      3'd4: begin a = 1'b1; x = op[3]; end
      3'd5: begin a = (op != 8'h05); x = op[3]; end
      3'd6: a = (op[4:3] == 2'b10);
      3'd7: begin a = (op == 8'h07); x = (op == 8'h87); end
      default: ;
    endcase
    return {a, x};
  endfunction

  function automatic logic [7:0] rand_op_lo();
    logic [7:0] lo;
    lo = 8'($urandom());
    if (lo[2:0] == 3'd7) begin
      case ($urandom_range(0, 2))
        0: lo = 8'h07;
        1: lo = 8'h87;
        default: ;
      endcase
    end else if (lo[2:0] == 3'd5 && $urandom_range(0, 3) == 0) begin
      lo = 8'h05;
    end
    return lo;
  endfunction

  task automatic set_inst(input int addr, input logic [15:0] op);
    mem[addr] = {op, 8'($urandom()), 8'($urandom()), 32'($urandom())};
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model
  task automatic cycle(input bit st, input bit rdy, input bit a2, input bit x2,
                       input bit a3, input bit x3, input bit br, input logic [PW-1:0] tgt);
    logic [63:0] inst;
    logic [1:0]  rs;
    bit          hz, exp_valid, offered;
    @(negedge clk);
    start = st; s2_ready = rdy;
    s2_A_en = a2; s2_X_en = x2; s3_A_en = a3; s3_X_en = x3;
    branch_valid = br; branch_target = tgt;
    #1;
    offered   = m_busy && (m_wait == 0);
    inst      = mem[m_pc];
    rs        = exp_reads(inst[55:48]);
    hz        = offered && ((rs[1] && (a2 || a3)) || (rs[0] && (x2 || x3)));
    exp_valid = offered && !hz && !br;
    check("busy", 64'(busy), 64'(m_busy));
    check("rd_en", 64'(inst_rd_en), 64'(m_busy && m_wait == 2));
    if (m_busy && m_wait == 2) check("rd_addr", 64'(inst_rd_addr), 64'(m_pc));
    check("valid_out", 64'(valid_out), 64'(exp_valid));
    check("hazard_stall", 64'(hazard_stall), 64'(hz));
    if (offered) begin
      check("pc_out", 64'(pc_out), 64'(m_pc));
      check("inst_fields", {opcode_out, jt_out, jf_out, k_out}, inst);
      check("reads", 64'({reads_A, reads_X}), 64'(rs));
    end
`ifdef STALL_COUNTER_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    if (hz && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (!m_busy) begin
      if (st) begin m_busy = 1'b1; m_pc = '0; m_wait = 2; m_stall = 0; end
    end else if (br) begin
      m_pc = tgt; m_wait = 2;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (exp_valid && rdy) begin
      if (inst[50:48] == 3'd6) m_busy = 1'b0;
      else begin m_pc = m_pc + PW'(1); m_wait = 2; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic go();
    cycle(1, 0, 0, 0, 0, 0, 0, '0);
    idle(2);
  endtask

  task automatic reset_and_check();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_en", 64'(inst_rd_en), 64'(0));
    check("rst_rd_addr", 64'(inst_rd_addr), 64'(0));
    check("rst_valid", 64'(valid_out), 64'(0));
    check("rst_fields", {opcode_out, jt_out, jf_out, k_out}, 64'(0));
    check("rst_reads", 64'({reads_A, reads_X}), 64'(0));
    check("rst_stall", 64'(hazard_stall), 64'(0));
`ifdef STALL_COUNTER_EN
    check("rst_stall_cycles", 64'(stall_cycles), 64'(0));
`endif
    m_busy = 1'b0; m_wait = 0; m_pc = '0; m_stall = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << PW); i++) set_inst(i, {8'($urandom()), rand_op_lo()});
    repeat (2) @(negedge clk);
    reset_and_check();

    // RET K: strobe at cycle 1, offered at cycle 3, idle after transfer
    set_inst(0, 16'h0006);
    go();
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(1);

    // ALU ADD X held by stage-3 X write for two cycles, then issues
    set_inst(0, 16'h000C);
    set_inst(1, 16'h0006);
    go();
    cycle(0, 1, 0, 0, 0, 1, 0, '0);
    cycle(0, 1, 0, 0, 0, 1, 0, '0);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(1);

    // TAX with only an X write pending issues immediately
    set_inst(0, 16'h0007);
    go();
    cycle(0, 1, 0, 1, 0, 0, 0, '0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);

    // Branch in ISSUE beats transfer; then branch during the strobe cycle of FETCH
    set_inst(0, 16'h0000);
    set_inst(16'h3F, 16'h0006);
    go();
    cycle(0, 1, 0, 0, 0, 0, 1, PW'(16'h3F));
    cycle(0, 1, 0, 0, 0, 0, 1, PW'(16'h3F));
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(1);

    // PC wrap from 0x3FF to 0x000
    set_inst(0, 16'h0004);
    set_inst(10'h3FF, 16'h0000);
    go();
    cycle(0, 1, 0, 0, 0, 0, 1, 10'h3FF);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 1, PW'(16'h3F));
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);

    // Five hazard cycles, then a fresh start clears the counter
    set_inst(0, 16'h0004);
    set_inst(1, 16'h0006);
    go();
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    go();
    cycle(0, 1, 0, 0, 0, 0, 0, '0);
    idle(2);
    cycle(0, 1, 0, 0, 0, 0, 0, '0);

    // Reset during FETCH: returning data ignored, stays idle without start
    go();
    reset_and_check();
    idle(3);

    // Randomized traffic
    for (int i = 0; i < (1 << PW); i++) set_inst(i, {8'($urandom()), rand_op_lo()});
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 11) == 0), PW'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
